// File: rtl/mic_level_meter.sv
// mic_level_meter: windowed peak detector that quantises mic amplitude into a
// 17-level thermometer code with rise-fast / fall-slow smoothing.
module mic_level_meter #(
    parameter int WINDOW     = 4000,
    parameter int BASE       = 2048,
    parameter int STEP_SHIFT = 7,
    parameter bit DECAY_EN   = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        sample_valid,
    input  logic [11:0] mic_in,
    output logic [15:0] level,
    output logic [4:0]  level_num,
    output logic        update
);
    logic [11:0] peak_q, peak_d, wp, excess, steps;
    logic [15:0] cnt_q, cnt_d;
    logic [4:0]  num_q, num_d, new_lvl;
    logic [15:0] therm_q, therm_d;
    logic        upd_q, last;

    always_comb begin
        wp      = (mic_in > peak_q) ? mic_in : peak_q;
        excess  = (wp > 12'(BASE)) ? wp - 12'(BASE) : 12'd0;
        steps   = excess >> STEP_SHIFT;
        new_lvl = (excess == 12'd0) ? 5'd0 : (steps > 12'd15) ? 5'd16 : steps[4:0] + 5'd1;
        num_d   = (new_lvl >= num_q || !DECAY_EN) ? new_lvl : num_q - 5'd1;
        therm_d = 16'((17'd1 << num_d) - 17'd1);
        last    = cnt_q == 16'(WINDOW - 1);
        cnt_d   = last ? 16'd0 : cnt_q + 16'd1;
        // The final sample is folded into wp above, so the next window starts empty.
        peak_d  = last ? 12'd0 : wp;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            peak_q  <= '0;
            cnt_q   <= '0;
            num_q   <= '0;
            therm_q <= '0;
            upd_q   <= 1'b0;
        end else begin
            upd_q <= 1'b0;
            if (sample_valid) begin
                cnt_q  <= cnt_d;
                peak_q <= peak_d;
                if (last) begin
                    num_q   <= num_d;
                    therm_q <= therm_d;
                    upd_q   <= 1'b1;
                end
            end
        end
    end

    assign level     = therm_q;
    assign level_num = num_q;
    assign update    = upd_q;
endmodule

// File: tb/tb_mic_level_meter.sv
// tb_mic_level_meter: drives two WINDOW=4 meters (decay on / off) with shared
// stimulus and checks them against a window-queue reference model.
module tb_mic_level_meter;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        sample_valid = 1'b0;
    logic [11:0] mic_in = '0;
    logic [15:0] lvl_d, lvl_n;
    logic [4:0]  num_d, num_n;
    logic        upd_d, upd_n;

    int errors = 0;
    int checks = 0;
    int exp_d = 0;
    int exp_n = 0;
    bit exp_upd = 1'b0;
    int win[$];

    always #5 clock = ~clock;

    mic_level_meter #(.WINDOW(4), .DECAY_EN(1'b1)) dut_d (
        .clock(clock), .reset(reset), .sample_valid(sample_valid), .mic_in(mic_in),
        .level(lvl_d), .level_num(num_d), .update(upd_d));

    mic_level_meter #(.WINDOW(4), .DECAY_EN(1'b0)) dut_n (
        .clock(clock), .reset(reset), .sample_valid(sample_valid), .mic_in(mic_in),
        .level(lvl_n), .level_num(num_n), .update(upd_n));

    function automatic int qlvl(input int wp);
        int ex = (wp > 2048) ? wp - 2048 : 0;
        if (ex == 0) return 0;
        return (ex / 128 + 1 > 16) ? 16 : ex / 128 + 1;
    endfunction

    function automatic logic [15:0] therm(input int n);
        logic [15:0] t = '0;
        for (int i = 0; i < n; i++) t[i] = 1'b1;
        return t;
    endfunction

    task automatic model_push(input int v);
        int m = 0;
        win.push_back(v);
        exp_upd = 1'b0;
        if (win.size() == 4) begin
            foreach (win[i]) m = (win[i] > m) ? win[i] : m;
            exp_n = qlvl(m);
            exp_d = (qlvl(m) >= exp_d) ? qlvl(m) : exp_d - 1;
            win.delete();
            exp_upd = 1'b1;
        end
    endtask

    task automatic accept(input int v);
        sample_valid = 1'b1;
        mic_in = 12'(v);
        @(posedge clock);
        model_push(v);
        #1 sample_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        sample_valid = 1'b0;
        repeat (n) @(posedge clock);
        exp_upd = 1'b0;
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        sample_valid = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        exp_d = 0;
        exp_n = 0;
        exp_upd = 1'b0;
        win.delete();
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({upd_d, num_d, lvl_d, upd_n, num_n, lvl_n} !== '0) begin
            errors++;
            $display("FAIL reset_state: d=%b/%0d/%h n=%b/%0d/%h, want all zero", upd_d, num_d, lvl_d, upd_n, num_n, lvl_n);
        end
        for (int i = 0; i < 3; i++) accept(4095);
        do_reset();
        checks++;
        if ({upd_d, num_d, lvl_d} !== '0) begin
            errors++;
            $display("FAIL reset_mid_window: d=%b/%0d/%h want 0/0/0000", upd_d, num_d, lvl_d);
        end
        for (int i = 0; i < 4; i++) accept(2048);
        checks++;
        if ({upd_d, num_d, upd_n, num_n} !== {1'b1, 5'd0, 1'b1, 5'd0}) begin
            errors++;
            $display("FAIL reset_discard: upd/num d=%b/%0d n=%b/%0d want 1/0", upd_d, num_d, upd_n, num_n);
        end
    endtask

    task automatic test_quant();
        int peaks[7] = '{2048, 2049, 2175, 2176, 3071, 3968, 4095};
        int lvls[7]  = '{0, 1, 1, 2, 8, 16, 16};
        do_reset();
        for (int k = 0; k < 7; k++) begin
            accept(2048); accept(peaks[k]); accept(1000); accept(2048);
            checks++;
            if ({upd_n, num_n, lvl_n} !== {1'b1, 5'(lvls[k]), therm(lvls[k])} || exp_n != lvls[k]) begin
                errors++;
                $display("FAIL quant peak=%0d: num=%0d lvl=%h upd=%b want %0d/%h/1", peaks[k], num_n, lvl_n, upd_n, lvls[k], therm(lvls[k]));
            end
            checks++;
            if ({upd_d, num_d, lvl_d} !== {exp_upd, 5'(exp_d), therm(exp_d)}) begin
                errors++;
                $display("FAIL quant_decay peak=%0d: num=%0d lvl=%h want %0d/%h", peaks[k], num_d, lvl_d, exp_d, therm(exp_d));
            end
        end
    endtask

    task automatic test_peak_place();
        do_reset();
        accept(2048); accept(2048); accept(2048); accept(3071);
        checks++;
        if ({upd_d, num_d, upd_n, num_n} !== {1'b1, 5'd8, 1'b1, 5'd8}) begin
            errors++;
            $display("FAIL peak_last: d=%b/%0d n=%b/%0d want 1/8", upd_d, num_d, upd_n, num_n);
        end
        for (int i = 0; i < 4; i++) accept(2048);
        checks++;
        if ({num_d, lvl_d, num_n, lvl_n} !== {5'd7, 16'h007F, 5'd0, 16'h0000}) begin
            errors++;
            $display("FAIL peak_next_window: d=%0d/%h n=%0d/%h want 7/007f 0/0000", num_d, lvl_d, num_n, lvl_n);
        end
    endtask

    task automatic test_decay();
        int vals[6] = '{4095, 2048, 2048, 2048, 3071, 4095};
        int want[6] = '{16, 15, 14, 13, 12, 16};
        do_reset();
        for (int k = 0; k < 6; k++) begin
            for (int i = 0; i < 4; i++) accept(i == 2 ? vals[k] : 2048);
            checks++;
            if ({upd_d, num_d, lvl_d} !== {1'b1, 5'(want[k]), therm(want[k])} || exp_d != want[k]) begin
                errors++;
                $display("FAIL decay step %0d: num=%0d lvl=%h want %0d/%h", k, num_d, lvl_d, want[k], therm(want[k]));
            end
            checks++;
            if ({upd_n, num_n, lvl_n} !== {exp_upd, 5'(exp_n), therm(exp_n)}) begin
                errors++;
                $display("FAIL decay_off step %0d: num=%0d lvl=%h want %0d/%h", k, num_n, lvl_n, exp_n, therm(exp_n));
            end
        end
    endtask

    task automatic test_gapped();
        do_reset();
        for (int s = 0; s < 8; s++) begin
            accept(2560);
            checks++;
            if ({upd_d, num_d, lvl_d, upd_n, num_n, lvl_n} !== {exp_upd, 5'(exp_d), therm(exp_d), exp_upd, 5'(exp_n), therm(exp_n)} || (exp_upd && exp_d != 5)) begin
                errors++;
                $display("FAIL gapped sample %0d: d=%b/%0d n=%b/%0d want %b/%0d", s, upd_d, num_d, upd_n, num_n, exp_upd, exp_d);
            end
            for (int g = 0; g < 4; g++) begin
                idle(1);
                checks++;
                if ({upd_d, lvl_d, upd_n, lvl_n} !== {1'b0, therm(exp_d), 1'b0, therm(exp_n)}) begin
                    errors++;
                    $display("FAIL gapped idle %0d.%0d: upd=%b/%b lvl=%h/%h want 0 %h/%h", s, g, upd_d, upd_n, lvl_d, lvl_n, therm(exp_d), therm(exp_n));
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int c = 0; c < 16; c++) begin
            accept(4095);
            checks++;
            if ({upd_d, upd_n} !== {2{c % 4 == 3}} || (c >= 3 && {lvl_d, lvl_n} !== 32'hFFFF_FFFF)) begin
                errors++;
                $display("FAIL back_to_back cycle %0d: upd=%b/%b lvl=%h/%h want upd=%b", c, upd_d, upd_n, lvl_d, lvl_n, c % 4 == 3);
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int s = 0; s < 200; s++) begin
            accept((($urandom % 4) == 0) ? int'($urandom % 4096) : int'(1900 + $urandom % 400));
            checks++;
            if ({upd_d, num_d, lvl_d, upd_n, num_n, lvl_n} !== {exp_upd, 5'(exp_d), therm(exp_d), exp_upd, 5'(exp_n), therm(exp_n)}) begin
                errors++;
                $display("FAIL random sample %0d: d=%b/%0d/%h n=%b/%0d/%h want %b d=%0d n=%0d", s, upd_d, num_d, lvl_d, upd_n, num_n, lvl_n, exp_upd, exp_d, exp_n);
            end
            if ($urandom % 3 == 0) idle(1 + $urandom % 3);
        end
    endtask

    initial begin
        test_reset();
        test_quant();
        test_peak_place();
        test_decay();
        test_gapped();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mic_level_meter.md
Name: mic_level_meter

Overview:
- Upstream stage of the OLED volume soundbar renderer; converts raw 12-bit microphone samples into the 16-bit thermometer volume code that the renderer draws as bars.
- Tracks the peak sample over a fixed window of samples, quantises the peak into 17 levels (0..16) and applies rise-fast / fall-slow smoothing.
- Drives the renderer's 16-bit level input directly; the level is held stable between window updates.

Parameters:
- WINDOW, 4000, samples per measurement window (0.2 s at 20 kHz); legal range 2..65535
- BASE, 2048, mic idle midpoint; samples at or below BASE contribute zero amplitude
- STEP_SHIFT, 7, log2 of amplitude counts per level step
- DECAY_EN, 1, 1 = falls limited to one level per window; 0 = output jumps directly to the new level

Ports:
- clock  in  1  system clock; all state changes on its rising edge
- reset  in  1  synchronous, active-high reset
- sample_valid  in  1  one-cycle strobe; mic_in is valid and is consumed this cycle
- mic_in  in  12  unsigned microphone sample
- level  out  16  thermometer code: the low level_num bits are 1 and all others are 0
- level_num  out  5  current level, 0..16
- update  out  1  one-cycle pulse in the cycle level/level_num take a new window result

Behaviour:
- Reset (synchronous; has priority over everything): level=0, level_num=0, update=0, peak register=0, sample counter=0. Reset applied mid-window discards the partial window; the next accepted sample starts a fresh window.
- Cycles with sample_valid=0 change no state except update, which is 0.
- Accepted sample (sample_valid=1): peak_next = max(peak, mic_in).
- Sample counter:
  - Runs 0..WINDOW-1 and advances only on accepted samples.
  - On the sample accepted at count WINDOW-1, the counter wraps to 0.
  - In that same cycle, wp = max(peak, mic_in) is evaluated, so the final sample is included in the window.
  - The peak register is then loaded with 0, not with mic_in.
- Quantisation of wp:
  - excess = wp - BASE when wp > BASE, otherwise 0 (12-bit unsigned, no wrap).
  - new_lvl = 0 if excess = 0; otherwise min(16, (excess >> STEP_SHIFT) + 1).
  - With defaults: excess 1..127 gives 1; 1920..2047 gives 16; wp = 4095 gives 16.
- Smoothing: applied on the clock edge that ends the window; the result is visible the next cycle.
  - new_lvl >= level_num: level_num = new_lvl.
  - new_lvl < level_num and DECAY_EN=1: level_num = level_num - 1.
  - new_lvl < level_num and DECAY_EN=0: level_num = new_lvl.
- level is registered and always equals the thermometer form of level_num:
  - 0 gives 16'h0000; 1 gives 16'h0001; 8 gives 16'h00FF; 16 gives 16'hFFFF.
  - No other bit patterns ever appear; the renderer has no default branch.
- update=1 for exactly one cycle, in the cycle level first shows the window result. It pulses even when the value is unchanged.
- Latency: level, level_num and update all change 1 clock after the edge that accepts the final window sample.
- sample_valid held high continuously is legal; one sample is accepted every cycle.
- Arithmetic: peak is 12 bits. The counter is 16 bits and must never exceed WINDOW-1.

Test Plan:
- Reset behaviour: WINDOW=4; feed 3 samples of 4095, assert reset, then release -> level=0, level_num=0, update=0. The next 4 samples of 2048 produce update with level_num=0, showing the partial window was discarded.
- Quantisation sweep: WINDOW=4, DECAY_EN=0; windows with peaks 2048, 2049, 2175, 2176, 3071, 3968, 4095 -> level_num 0, 1, 1, 2, 8, 16, 16. Level shows 16'h0000, 0001, 0001, 0003, 00FF, FFFF, FFFF.
- Peak placement: WINDOW=4, samples {2048, 2048, 2048, 3071}. The max arrives on the last sample, and the next window's first sample is 2048 -> first window level_num=8; second window (all 2048) gives 7 with DECAY_EN=1 and 0 with DECAY_EN=0.
- Decay then rise: DECAY_EN=1; one window at 4095, then quiet 2048 windows -> level_num 16, 15, 14, 13. A window at 3071 then jumps to 8 only if 8 >= current; from 13 it gives 12. A window at 4095 gives 16 immediately.
- Gapped strobes: WINDOW=4; sample_valid pulsed every 5th cycle with value 2560 -> update after exactly 4 accepted samples with level_num=5, and level is unchanged between updates.
- Back-to-back: sample_valid=1 every cycle at 4095, WINDOW=4 -> update pulses every 4 cycles, level stays 16'hFFFF, and the counter never exceeds 3.
